sti_serializer: RTL and testbench
=================================

Name: sti_serializer

Overview:
Serial transmitter paired with the DAC serial receiver. It takes one 16-bit parallel word per load pulse and builds an 8/16/24/32-bit frame, using selectable byte choice, fill alignment and bit order. It shifts the frame out one bit per clock on so_data, qualified by so_valid, and raises done once the word flagged as last has been fully sent. It sits between the parallel test/host source and the DAC's so_data/so_valid inputs.

Parameters:
CNT_W, 6, width of internal bit counter; must hold values 0..32.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
load  input  1  one-cycle request to transmit pi_data; honoured only in IDLE
pi_data  input  16  parallel payload
pi_length  input  2  frame length code: 00=8, 01=16, 10=24, 11=32 bits
pi_fill  input  1  24/32-bit modes: 1 = payload in frame MSBs, zeros below; 0 = zeros above, payload in LSBs
pi_msb  input  1  1 = frame MSB sent first; 0 = frame LSB sent first
pi_low  input  1  8-bit mode: 1 = send pi_data[15:8]; 0 = send pi_data[7:0]
pi_end  input  1  marks this word as the final one
so_data  output  1  serial data bit; 0 whenever so_valid=0
so_valid  output  1  high on every cycle carrying a frame bit
busy  output  1  high while a frame is in progress (state SHIFT)
done  output  1  sticky end-of-stream flag

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE; so_data, so_valid, busy and done are 0. The frame register and counter are cleared. Reset aborts any frame in progress; outputs are 0 from the next cycle.
- States: IDLE, SHIFT, DONE.
- IDLE, load=1 at edge T: latch all pi_* inputs, build the frame, set counter=L, go to SHIFT. In IDLE with load=0, stay in IDLE.
- Frame build, with L=8*(pi_length+1):
  - L=8: frame = pi_low ? pi_data[15:8] : pi_data[7:0].
  - L=16: frame = pi_data.
  - L=24/32, pi_fill=1: frame = {pi_data, (L-16) zeros}.
  - L=24/32, pi_fill=0: frame = {(L-16) zeros, pi_data}.
- SHIFT:
  - so_valid=1 and busy=1 on cycles T+1 .. T+L, exactly L consecutive cycles with no gaps.
  - pi_msb=1: cycle T+k outputs frame[L-k]. pi_msb=0: cycle T+k outputs frame[k-1].
  - Outputs are registered; input changes after T have no effect on the frame in flight.
- End of frame, after the last bit:
  - Latched pi_end=0: return to IDLE; so_valid=0 at T+L+1. The earliest next load is accepted at edge T+L+1, so its first bit is at T+L+2. There is always at least one idle cycle between frames.
  - Latched pi_end=1: go to DONE; done=1 from T+L+1 and held until reset.
- load while in SHIFT or DONE is ignored. Nothing is queued and no error is flagged.
- DONE: so_valid=0, so_data=0, busy=0, done=1. Only rst leaves DONE.
- load=1 together with rst=1: reset wins and the load is dropped.
- Counter decrements once per SHIFT cycle and never wraps. Leaving SHIFT happens when the counter reaches 1 after the final bit is emitted.
- pi_fill is ignored for L=8/16; pi_low is ignored for L≠8.

Test Plan:
- 8-bit, pi_data=16'h1E96, pi_low=0, pi_msb=1, load at T -> so_valid high T+1..T+8; bits 1,0,0,1,0,1,1,0; so_valid=0 at T+9.
- 8-bit, same data, pi_low=1, pi_msb=0 -> bits 0,1,1,1,1,0,0,0 (16'h1E sent LSB first). Repeat with pi_low=0, pi_msb=0 -> 0,1,1,0,1,0,0,1.
- 24-bit, pi_data=16'h8001, pi_msb=1:
  - pi_fill=1 -> 1, fourteen 0s, 1, eight 0s.
  - pi_fill=0 -> eight 0s, 1, fourteen 0s, 1.
  - so_valid high for exactly 24 cycles in each case.
- 32-bit, pi_data=16'h0001, pi_fill=0, pi_msb=0 -> first bit 1, then 31 zeros. Pulse load again mid-frame -> ignored, frame unchanged. Next load at T+33 -> first bit at T+34.
- Stream of 3 words, last with pi_end=1 -> three correct frames; done=1 the cycle after the final bit and held. A later load produces no so_valid.
- rst asserted mid-frame, at bit 5 of a 16-bit frame -> so_valid/so_data/busy=0 next cycle. A subsequent load sends a full fresh 16-bit frame.

Source files
------------

// File: rtl/sti_serializer.sv
// -----------------------------------------------------------------------------
// sti_serializer
//
// Serial transmitter feeding the DAC serial receiver. Each load pulse accepted
// in IDLE captures one 16-bit parallel word plus its framing controls, builds
// an 8/16/24/32-bit frame and shifts it out one bit per clock on so_data,
// qualified by so_valid. A word flagged with pi_end ends the stream: once its
// last bit is out the block parks in DONE with done held high until reset.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset, aborts any frame in flight
//   load       one-cycle transmit request, honoured only in IDLE
//   pi_data    16-bit parallel payload
//   pi_length  frame length code: 00=8, 01=16, 10=24, 11=32 bits
//   pi_fill    24/32-bit: 1 = payload in frame MSBs, 0 = payload in LSBs
//   pi_msb     1 = frame MSB first, 0 = frame LSB first
//   pi_low     8-bit: 1 = send pi_data[15:8], 0 = send pi_data[7:0]
//   pi_end     marks the final word of the stream
//   so_data    serial data bit, 0 whenever so_valid is 0
//   so_valid   high on every cycle carrying a frame bit
//   busy       high while a frame is being shifted
//   done       sticky end-of-stream flag
// -----------------------------------------------------------------------------
module sti_serializer #(
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] pi_data,
  input  logic [1:0]  pi_length,
  input  logic        pi_fill,
  input  logic        pi_msb,
  input  logic        pi_low,
  input  logic        pi_end,
  output logic        so_data,
  output logic        so_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [31:0]      shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic             end_flag;

  logic             load_go;
  logic             last_bit;
  logic [31:0]      load_word;
  logic [CNT_W-1:0] load_len;

  // Frame contents, right-justified in 32 bits (bit L-1 is the frame MSB).
  function automatic logic [31:0] build_frame(input logic [15:0] d,
                                              input logic [1:0]  len,
                                              input logic        fill,
                                              input logic        low);
    logic [31:0] fr;
    case (len)
      2'd0:    fr = {24'd0, (low ? d[15:8] : d[7:0])};
      2'd1:    fr = {16'd0, d};
      2'd2:    fr = fill ? {8'd0, d, 8'd0} : {16'd0, d};
      default: fr = fill ? {d, 16'd0}      : {16'd0, d};
    endcase
    return fr;
  endfunction

  function automatic logic [31:0] bit_reverse(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[31-i] = v[i];
    end
    return r;
  endfunction

  // Reorders the frame so the bit to transmit first sits at [31] and every
  // following bit comes out of a plain left shift. For LSB-first the reversal
  // also moves the zero padding above the frame below the last bit, so it
  // never reaches the line.
  function automatic logic [31:0] align_first(input logic [31:0] fr,
                                              input logic [1:0]  len,
                                              input logic        msb);
    logic [31:0] r;
    if (msb) begin
      case (len)
        2'd0:    r = fr << 24;
        2'd1:    r = fr << 16;
        2'd2:    r = fr << 8;
        default: r = fr;
      endcase
    end else begin
      r = bit_reverse(fr);
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] frame_bits(input logic [1:0] len);
    return CNT_W'({len, 3'b000}) + CNT_W'(8);
  endfunction

  always_comb begin
    load_word = align_first(build_frame(pi_data, pi_length, pi_fill, pi_low),
                            pi_length, pi_msb);
    load_len  = frame_bits(pi_length);
  end

  assign load_go  = (state == IDLE) && load;
  // The counter holds the number of bits still on the line including the one
  // being shown; at 1 the final bit is out and SHIFT is left on this edge.
  assign last_bit = (state == SHIFT) && (bit_cnt == CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          state_next = end_flag ? DONE : IDLE;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs. The first frame bit is driven on the
  // load edge so it appears the cycle right after load is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      end_flag  <= 1'b0;
      so_data   <= 1'b0;
      so_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      so_valid <= (state_next == SHIFT);
      busy     <= (state_next == SHIFT);
      done     <= (state_next == DONE);
      if (load_go) begin
        so_data   <= load_word[31];
        shift_reg <= {load_word[30:0], 1'b0};
        bit_cnt   <= load_len;
        end_flag  <= pi_end;
      end else if (last_bit) begin
        so_data   <= 1'b0;
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (state == SHIFT) begin
        so_data   <= shift_reg[31];
        shift_reg <= {shift_reg[30:0], 1'b0};
        bit_cnt   <= bit_cnt - CNT_W'(1);
      end else begin
        so_data   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sti_serializer.sv
module tb_sti_serializer;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_fill;
  logic        pi_msb;
  logic        pi_low;
  logic        pi_end;
  logic        so_data;
  logic        so_valid;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  sti_serializer #(.CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .pi_data   (pi_data),
    .pi_length (pi_length),
    .pi_fill   (pi_fill),
    .pi_msb    (pi_msb),
    .pi_low    (pi_low),
    .pi_end    (pi_end),
    .so_data   (so_data),
    .so_valid  (so_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Expected serial sequence straight from the frame rules. Bits are packed
  // first-transmitted in the highest used position: seq[L-1] is bit 1.
  function automatic logic [31:0] model_seq(input logic [15:0] d,
                                            input logic [1:0]  len,
                                            input logic        fill,
                                            input logic        msb,
                                            input logic        low);
    int          l;
    logic [31:0] fr;
    logic [31:0] seq;
    l = 8 * (int'(len) + 1);
    if (l == 8)       fr = low ? 32'(d >> 8) : 32'(d & 16'h00FF);
    else if (l == 16) fr = 32'(d);
    else if (fill)    fr = 32'(d) << (l - 16);
    else              fr = 32'(d);
    seq = '0;
    for (int k = 1; k <= l; k++) begin
      seq = {seq[30:0], (msb ? fr[l-k] : fr[k-1])};
    end
    return seq;
  endfunction

  task automatic do_load(input logic [15:0] d, input logic [1:0] len,
                         input logic fill, input logic msb, input logic low,
                         input logic e);
    pi_data   = d;
    pi_length = len;
    pi_fill   = fill;
    pi_msb    = msb;
    pi_low    = low;
    pi_end    = e;
    load      = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // Collects one burst of so_valid after a load edge (bounded to 40 cycles).
  // pulse_at != 0 raises a foreign load and scrambles inputs on that cycle.
  task automatic capture(input int pulse_at, output logic [31:0] bits,
                         output int n, output int first_off,
                         output int busy_bad, output int idle_bad);
    bits = '0; n = 0; first_off = 0; busy_bad = 0; idle_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (so_valid) begin
        if (n == 0) first_off = c;
        bits = {bits[30:0], so_data};
        n++;
        if (busy !== 1'b1) busy_bad++;
      end else begin
        if (so_data !== 1'b0) idle_bad++;
        if (busy !== 1'b0) busy_bad++;
      end
      if (c == pulse_at) begin
        load      = 1'b1;
        pi_data   = 16'($urandom);
        pi_length = 2'($urandom);
        pi_fill   = ~pi_fill;
        pi_msb    = ~pi_msb;
        pi_low    = ~pi_low;
        pi_end    = 1'b1;
      end else begin
        load = 1'b0;
      end
      if (!so_valid && n > 0) break;
    end
    load = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    load = 1'b1;
    pi_data = 16'hFFFF; pi_length = 2'd3; pi_fill = 1'b0; pi_msb = 1'b1;
    pi_low = 1'b0; pi_end = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({so_valid, so_data, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got valid/data/busy/done=%b required 0000",
               {so_valid, so_data, busy, done});
    end
    rst = 1'b0;
    load = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({so_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_load_dropped: got valid/busy/done=%b required 000",
               {so_valid, busy, done});
    end
  endtask

  task automatic test_8bit();
    logic [31:0] bits;
    int n, f, bb, ib;
    logic [7:0] want [3];
    logic       low_v [3];
    logic       msb_v [3];
    want[0] = 8'h96; low_v[0] = 1'b0; msb_v[0] = 1'b1;
    want[1] = 8'h78; low_v[1] = 1'b1; msb_v[1] = 1'b0;
    want[2] = 8'h69; low_v[2] = 1'b0; msb_v[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      do_load(16'h1E96, 2'd0, 1'b1, msb_v[i], low_v[i], 1'b0);
      capture(0, bits, n, f, bb, ib);
      checks++;
      if (n !== 8 || f !== 1) begin
        errors++;
        $display("FAIL 8bit_len case%0d: got len=%0d start=%0d required len=8 start=1", i, n, f);
      end
      checks++;
      if (bits !== {24'd0, want[i]} || bb !== 0 || ib !== 0) begin
        errors++;
        $display("FAIL 8bit_bits case%0d: got %h (busy_bad=%0d idle_bad=%0d) required %h",
                 i, bits, bb, ib, want[i]);
      end
    end
  endtask

  task automatic test_24bit();
    logic [31:0] bits;
    int n, f, bb, ib;
    logic [31:0] want;
    for (int i = 0; i < 2; i++) begin
      want = (i == 0) ? 32'h0080_0100 : 32'h0000_8001;
      @(negedge clk);
      do_load(16'h8001, 2'd2, (i == 0), 1'b1, 1'b1, 1'b0);
      capture(0, bits, n, f, bb, ib);
      checks++;
      if (n !== 24 || f !== 1) begin
        errors++;
        $display("FAIL 24bit_len fill=%0d: got len=%0d start=%0d required len=24 start=1",
                 (i == 0), n, f);
      end
      checks++;
      if (bits !== want || bb !== 0 || ib !== 0) begin
        errors++;
        $display("FAIL 24bit_bits fill=%0d: got %h required %h", (i == 0), bits, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bits;
    int n, f, bb, ib;
    logic [15:0] d2;
    @(negedge clk);
    do_load(16'h0001, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(10, bits, n, f, bb, ib);
    checks++;
    if (n !== 32 || f !== 1 || bits !== 32'h8000_0000 || bb !== 0 || ib !== 0) begin
      errors++;
      $display("FAIL 32bit_ignore_load: got len=%0d bits=%h required len=32 bits=80000000", n, bits);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL 32bit_gap: got busy=%b done=%b required 0 0", busy, done);
    end
    // Load on the very first idle edge after the frame.
    d2 = 16'($urandom);
    do_load(d2, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    capture(0, bits, n, f, bb, ib);
    checks++;
    if (f !== 1 || n !== 16 || bits !== model_seq(d2, 2'd1, 1'b0, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL back_to_back: got start=%0d len=%0d bits=%h required start=1 len=16 bits=%h",
               f, n, bits, model_seq(d2, 2'd1, 1'b0, 1'b1, 1'b0));
    end
  endtask

  task automatic test_random();
    logic [31:0] bits;
    int n, f, bb, ib, l;
    logic [15:0] d;
    logic [1:0]  len;
    logic        fl, ms, lo;
    for (int i = 0; i < 24; i++) begin
      d = 16'($urandom); len = 2'($urandom);
      fl = 1'($urandom); ms = 1'($urandom); lo = 1'($urandom);
      l = 8 * (int'(len) + 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_load(d, len, fl, ms, lo, 1'b0);
      capture((i % 3 == 0) ? 4 : 0, bits, n, f, bb, ib);
      checks++;
      if (n !== l || f !== 1) begin
        errors++;
        $display("FAIL random_len it%0d: got len=%0d start=%0d required len=%0d start=1", i, n, f, l);
      end
      checks++;
      if (bits !== model_seq(d, len, fl, ms, lo) || bb !== 0 || ib !== 0) begin
        errors++;
        $display("FAIL random_bits it%0d: got %h (busy_bad=%0d idle_bad=%0d) required %h",
                 i, bits, bb, ib, model_seq(d, len, fl, ms, lo));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] bits;
    int n, f, bb, ib;
    logic [15:0] d;
    @(negedge clk);
    do_load(16'hA5C3, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({so_valid, so_data, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_frame: got valid/data/busy/done=%b required 0000",
               {so_valid, so_data, busy, done});
    end
    rst = 1'b0;
    d = 16'($urandom) | 16'h8001;
    do_load(d, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(0, bits, n, f, bb, ib);
    checks++;
    if (n !== 16 || f !== 1 || bits !== model_seq(d, 2'd1, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL after_reset_frame: got len=%0d bits=%h required len=16 bits=%h",
               n, bits, model_seq(d, 2'd1, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_stream_done();
    logic [31:0] bits;
    int n, f, bb, ib, l;
    logic [15:0] d;
    logic [1:0]  len;
    logic        ms;
    for (int i = 0; i < 3; i++) begin
      d = 16'($urandom); len = 2'(i); ms = 1'($urandom);
      l = 8 * (i + 1);
      @(negedge clk);
      do_load(d, len, 1'b1, ms, 1'b0, (i == 2));
      capture(0, bits, n, f, bb, ib);
      checks++;
      if (n !== l || bits !== model_seq(d, len, 1'b1, ms, 1'b0)) begin
        errors++;
        $display("FAIL stream_word%0d: got len=%0d bits=%h required len=%0d bits=%h",
                 i, n, bits, l, model_seq(d, len, 1'b1, ms, 1'b0));
      end
      checks++;
      if (done !== (i == 2) || busy !== 1'b0) begin
        errors++;
        $display("FAIL stream_done_word%0d: got done=%b busy=%b required done=%b busy=0",
                 i, done, busy, (i == 2));
      end
    end
    repeat (4) @(negedge clk);
    do_load(16'hFFFF, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    capture(0, bits, n, f, bb, ib);
    checks++;
    if (n !== 0 || ib !== 0 || done !== 1'b1) begin
      errors++;
      $display("FAIL done_hold: got valid_cycles=%0d idle_bad=%0d done=%b required 0 0 1",
               n, ib, done);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; load = 1'b0; pi_data = '0; pi_length = '0;
    pi_fill = 1'b0; pi_msb = 1'b0; pi_low = 1'b0; pi_end = 1'b0;
    test_reset();
    test_8bit();
    test_24bit();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    test_stream_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
